// File: rtl/vedic_pkg.sv
// Shared types and helpers for the digit-serial Vedic multiplier controller.
package vedic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } vmc_state_t;

    localparam int DIGW = 2;

    function automatic int ndig(input int width);
        return width / DIGW;
    endfunction

endpackage

// File: rtl/vedic_mul2_core.sv
// Combinational 2x2 Vedic (Urdhva Tiryagbhyam) multiplier core built from two half adders.
module vedic_mul2_core (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] p
);

    logic cross_lo;
    logic cross_hi;
    logic cross_carry;
    logic vert_hi;

    assign cross_lo    = x[1] & y[0];
    assign cross_hi    = x[0] & y[1];
    assign cross_carry = cross_lo & cross_hi;
    assign vert_hi     = x[1] & y[1];

    assign p[0] = x[0] & y[0];
    assign p[1] = cross_lo ^ cross_hi;
    assign p[2] = vert_hi ^ cross_carry;
    assign p[3] = vert_hi & cross_carry;

endmodule

// File: rtl/vedic_mul_seq_ctrl.sv
// Digit-serial WIDTH x WIDTH unsigned multiplier reusing one 2x2 Vedic core, one digit pair per cycle.
// Optional build macro VEDIC_ZERO_SKIP_EN: zero operands bypass the BUSY sequence.
module vedic_mul_seq_ctrl
    import vedic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int NDIG = ndig(WIDTH);
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PW   = 2 * WIDTH;
    localparam logic [CW-1:0] LAST_IDX = CW'(NDIG - 1);

    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
        $error("vedic_mul_seq_ctrl: WIDTH must be even and >= 2");
    end

    vmc_state_t        state;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [CW-1:0]     i_cnt;
    logic [CW-1:0]     j_cnt;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     product_reg;

    logic [DIGW-1:0]   a_dig;
    logic [DIGW-1:0]   b_dig;
    logic [3:0]        core_p;
    logic [CW:0]       dig_sum;
    logic [CW+1:0]     shamt;
    logic [PW-1:0]     term;
    logic [PW-1:0]     acc_next;
    logic              last_pair;
    logic              accept;

    assign a_dig = a_reg[{i_cnt, 1'b0} +: DIGW];
    assign b_dig = b_reg[{j_cnt, 1'b0} +: DIGW];

    vedic_mul2_core u_core (
        .x (a_dig),
        .y (b_dig),
        .p (core_p)
    );

    // Partial product weight is 4^(i+j), i.e. a left shift of 2*(i+j) bits.
    assign dig_sum = {1'b0, i_cnt} + {1'b0, j_cnt};
    assign shamt   = {dig_sum, 1'b0};

    always_comb begin
        term      = '0;
        term[3:0] = core_p;
        term      = term << shamt;
    end

    assign acc_next  = acc + term;
    assign last_pair = (i_cnt == LAST_IDX) && (j_cnt == LAST_IDX);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            i_cnt       <= '0;
            j_cnt       <= '0;
            acc         <= '0;
            product_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg <= a;
                        b_reg <= b;
                        i_cnt <= '0;
                        j_cnt <= '0;
                        acc   <= '0;
`ifdef VEDIC_ZERO_SKIP_EN
                        if ((a == '0) || (b == '0)) begin
                            product_reg <= '0;
                            state       <= DONE;
                        end else begin
                            state <= BUSY;
                        end
`else
                        state <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    // The final pair's sum goes straight to the product so out_valid rises on this edge.
                    if (last_pair) begin
                        product_reg <= acc_next;
                        i_cnt       <= '0;
                        j_cnt       <= '0;
                        state       <= DONE;
                    end else if (j_cnt == LAST_IDX) begin
                        j_cnt <= '0;
                        i_cnt <= i_cnt + CW'(1);
                    end else begin
                        j_cnt <= j_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);
    assign product   = product_reg;

endmodule

// File: tb/tb_vedic_mul_seq_ctrl.sv
// Bench for vedic_mul_seq_ctrl at WIDTH 8, 2 and 16 against a plain-multiply reference model.
module tb_vedic_mul_seq_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        iv8, ir8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        iv2, ir2, ov2, or2, busy2;
    logic [1:0]  a2, b2;
    logic [3:0]  p2;

    logic        iv16, ir16, ov16, or16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    vedic_mul_seq_ctrl #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8)
    );

    vedic_mul_seq_ctrl #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .out_valid(ov2), .out_ready(or2), .product(p2), .busy(busy2)
    );

    vedic_mul_seq_ctrl #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .out_valid(ov16), .out_ready(or16), .product(p16), .busy(busy16)
    );

    int tests_run = 0;
    int fails     = 0;
    logic [31:0] exp_q[$];

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_product(input logic [15:0] av, input logic [15:0] bv);
        return 32'(av) * 32'(bv);
    endfunction

    function automatic int exp_lat(input int sel, input logic [15:0] av, input logic [15:0] bv);
        int nd;
        nd = (sel == 0) ? 4 : ((sel == 1) ? 1 : 8);
`ifdef VEDIC_ZERO_SKIP_EN
        if ((av == 16'd0) || (bv == 16'd0)) return 0;
`endif
        return nd * nd;
    endfunction

    // ---------------- DUT access helpers ----------------
    function automatic logic get_ov(input int sel);
        case (sel)
            0: return ov8;
            1: return ov2;
            default: return ov16;
        endcase
    endfunction

    function automatic logic get_ir(input int sel);
        case (sel)
            0: return ir8;
            1: return ir2;
            default: return ir16;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0: return busy8;
            1: return busy2;
            default: return busy16;
        endcase
    endfunction

    function automatic logic [31:0] get_prod(input int sel);
        case (sel)
            0: return 32'(p8);
            1: return 32'(p2);
            default: return p16;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int sel, input logic v, input logic [15:0] av, input logic [15:0] bv);
        case (sel)
            0: begin iv8 = v; a8 = av[7:0]; b8 = bv[7:0]; end
            1: begin iv2 = v; a2 = av[1:0]; b2 = bv[1:0]; end
            default: begin iv16 = v; a16 = av; b16 = bv; end
        endcase
    endtask

    task automatic set_or(input int sel, input logic v);
        case (sel)
            0: or8 = v;
            1: or2 = v;
            default: or16 = v;
        endcase
    endtask

    // Issue one operation, wait (bounded) for the result, optionally stall, then drain it.
    task automatic run_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                          input int hold, input bit noise,
                          output logic [31:0] p, output int lat, output bit busy_seen,
                          output bit ir_high_seen, output bit unstable);
        set_in(sel, 1'b1, av, bv);
        tick();
        set_in(sel, 1'b0, av, bv);
        lat = 0; busy_seen = 0; ir_high_seen = 0; unstable = 0;
        while (!get_ov(sel) && (lat < 200)) begin
            busy_seen    = busy_seen | get_busy(sel);
            ir_high_seen = ir_high_seen | get_ir(sel);
            if (noise) set_in(sel, 1'($urandom), 16'($urandom), 16'($urandom));
            tick();
            lat++;
        end
        set_in(sel, 1'b0, 16'd0, 16'd0);
        p = get_prod(sel);
        busy_seen    = busy_seen | get_busy(sel);
        ir_high_seen = ir_high_seen | get_ir(sel);
        for (int c = 0; c < hold; c++) begin
            tick();
            if ((get_prod(sel) !== p) || (get_ov(sel) !== 1'b1)) unstable = 1;
            if (get_ir(sel)) ir_high_seen = 1;
        end
        set_or(sel, 1'b1);
        tick();
        set_or(sel, 1'b0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        set_in(0, 1'b0, 16'd0, 16'd0); set_in(1, 1'b0, 16'd0, 16'd0); set_in(2, 1'b0, 16'd0, 16'd0);
        set_or(0, 1'b0); set_or(1, 1'b0); set_or(2, 1'b0);
        #1;
        tests_run++; if (ir8 !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", ir8); end
        tests_run++; if (ov8 !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", ov8); end
        tests_run++; if (busy8 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy8); end
        tests_run++; if (p8 !== 16'h0) begin fails++; $display("FAIL reset_product: got %h expected 0000", p8); end
        tests_run++; if ((ir2 !== 1'b1) || (ir16 !== 1'b1)) begin fails++; $display("FAIL reset_in_ready_w2_w16: got %b%b expected 11", ir2, ir16); end
        tests_run++; if (p16 !== 32'h0) begin fails++; $display("FAIL reset_product_w16: got %h expected 0", p16); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_scale();
        logic [31:0] p, e; int lat; bit bs, irs, uns;
        exp_q.push_back(ref_product(16'hFF, 16'hFF));
        run_op(0, 16'hFF, 16'hFF, 0, 0, p, lat, bs, irs, uns);
        e = exp_q.pop_front();
        tests_run++; if (p !== e) begin fails++; $display("FAIL full_scale_product: got %h expected %h", p, e); end
        tests_run++; if (lat !== 16) begin fails++; $display("FAIL full_scale_latency: got %0d expected 16", lat); end
        tests_run++; if (bs !== 1'b1) begin fails++; $display("FAIL full_scale_busy: got %b expected 1", bs); end
    endtask

    task automatic test_zero_operand();
        logic [31:0] p; int lat, el; bit bs, irs, uns;
        run_op(0, 16'd37, 16'd0, 0, 0, p, lat, bs, irs, uns);
        el = exp_lat(0, 16'd37, 16'd0);
        tests_run++; if (p !== 32'h0) begin fails++; $display("FAIL zero_product: got %h expected 0", p); end
        tests_run++; if (lat !== el) begin fails++; $display("FAIL zero_latency: got %0d expected %0d", lat, el); end
        tests_run++; if (bs !== (el != 0)) begin fails++; $display("FAIL zero_busy_seen: got %b expected %b", bs, (el != 0)); end
    endtask

    task automatic test_backpressure();
        logic [31:0] p; int lat; bit bs, irs, uns;
        run_op(0, 16'hA5, 16'h3C, 10, 0, p, lat, bs, irs, uns);
        tests_run++; if (p !== 32'h26AC) begin fails++; $display("FAIL bp_product: got %h expected 000026ac", p); end
        tests_run++; if (uns !== 1'b0) begin fails++; $display("FAIL bp_stable: got %b expected 0", uns); end
        tests_run++; if (irs !== 1'b0) begin fails++; $display("FAIL bp_in_ready_low: got %b expected 0", irs); end
        tests_run++; if (ov8 !== 1'b0) begin fails++; $display("FAIL bp_single_transfer: got %b expected 0", ov8); end
        tests_run++; if (ir8 !== 1'b1) begin fails++; $display("FAIL bp_back_to_idle: got %b expected 1", ir8); end
        tests_run++; if (p8 !== 16'h26AC) begin fails++; $display("FAIL bp_product_held: got %h expected 26ac", p8); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] p; int lat; bit bs, irs, uns;
        set_in(0, 1'b1, 16'h12, 16'h34);
        tick();
        set_in(0, 1'b0, 16'h0, 16'h0);
        for (int c = 0; c < 6; c++) tick();
        tests_run++; if (busy8 !== 1'b1) begin fails++; $display("FAIL mid_busy_before_reset: got %b expected 1", busy8); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (ir8 !== 1'b1) begin fails++; $display("FAIL mid_reset_in_ready: got %b expected 1", ir8); end
        tests_run++; if (ov8 !== 1'b0) begin fails++; $display("FAIL mid_reset_out_valid: got %b expected 0", ov8); end
        tests_run++; if (busy8 !== 1'b0) begin fails++; $display("FAIL mid_reset_busy: got %b expected 0", busy8); end
        tests_run++; if (p8 !== 16'h0) begin fails++; $display("FAIL mid_reset_product: got %h expected 0000", p8); end
        tick();
        rst_n = 1'b1;
        tick();
        tests_run++; if (ov8 !== 1'b0) begin fails++; $display("FAIL mid_no_emit: got %b expected 0", ov8); end
        run_op(0, 16'h12, 16'h34, 0, 0, p, lat, bs, irs, uns);
        tests_run++; if (p !== 32'h03A8) begin fails++; $display("FAIL mid_next_product: got %h expected 000003a8", p); end
        tests_run++; if (lat !== 16) begin fails++; $display("FAIL mid_next_latency: got %0d expected 16", lat); end
    endtask

    task automatic test_ignore_inputs();
        logic [31:0] p, e; int lat; bit bs, irs, uns;
        logic [15:0] av, bv;
        for (int n = 0; n < 4; n++) begin
            av = 16'($urandom_range(1, 255));
            bv = 16'($urandom_range(1, 255));
            exp_q.push_back(ref_product(av, bv));
            run_op(0, av, bv, 2, 1, p, lat, bs, irs, uns);
            e = exp_q.pop_front();
            tests_run++; if (p !== e) begin fails++; $display("FAIL ignore_product: got %h expected %h", p, e); end
            tests_run++; if (irs !== 1'b0) begin fails++; $display("FAIL ignore_in_ready: got %b expected 0", irs); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] p, e; int lat, el; bit bs, irs, uns;
        logic [15:0] av, bv;
        for (int n = 0; n < 30; n++) begin
            av = 16'($urandom_range(0, 255));
            bv = 16'($urandom_range(0, 255));
            exp_q.push_back(ref_product(av, bv));
            run_op(0, av, bv, 0, 0, p, lat, bs, irs, uns);
            e  = exp_q.pop_front();
            el = exp_lat(0, av, bv);
            tests_run++; if (p !== e) begin fails++; $display("FAIL b2b_product: got %h expected %h", p, e); end
            tests_run++; if (lat !== el) begin fails++; $display("FAIL b2b_latency: got %0d expected %0d", lat, el); end
        end
    endtask

    task automatic test_w2_sweep();
        logic [31:0] p, e; int lat, el; bit bs, irs, uns;
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                exp_q.push_back(ref_product(16'(x), 16'(y)));
                run_op(1, 16'(x), 16'(y), 0, 0, p, lat, bs, irs, uns);
                e  = exp_q.pop_front();
                el = exp_lat(1, 16'(x), 16'(y));
                tests_run++; if (p !== e) begin fails++; $display("FAIL w2_product %0d*%0d: got %h expected %h", x, y, p, e); end
                tests_run++; if (lat !== el) begin fails++; $display("FAIL w2_latency: got %0d expected %0d", lat, el); end
            end
        end
    endtask

    task automatic test_w16_random();
        logic [31:0] p, e; int lat, el; bit bs, irs, uns;
        logic [15:0] av, bv;
        for (int n = 0; n < 400; n++) begin
            case (n)
                0: begin av = 16'hFFFF; bv = 16'hFFFF; end
                1: begin av = 16'hFFFF; bv = 16'h0001; end
                2: begin av = 16'h8000; bv = 16'h8000; end
                default: begin av = 16'($urandom); bv = 16'($urandom); end
            endcase
            exp_q.push_back(ref_product(av, bv));
            run_op(2, av, bv, 0, 0, p, lat, bs, irs, uns);
            e  = exp_q.pop_front();
            el = exp_lat(2, av, bv);
            tests_run++; if (p !== e) begin fails++; $display("FAIL w16_product %h*%h: got %h expected %h", av, bv, p, e); end
            tests_run++; if (lat !== el) begin fails++; $display("FAIL w16_latency: got %0d expected %0d", lat, el); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_full_scale();
        test_zero_operand();
        test_backpressure();
        test_reset_mid_op();
        test_ignore_inputs();
        test_back_to_back();
        test_w2_sweep();
        test_w16_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
